// File: rtl/amiga_reset_ctrl_if.sv
// Signal bundle between the reset controller and the A1000 board:
// keyboard clock and _RST sense in, _RST/_HLT drives and status out.
interface amiga_reset_ctrl_if;
  logic       KCLK;
  logic       RST_SENSE;
  logic       RST_DRV;
  logic       HLT_DRV;
  logic [1:0] CAUSE;
  logic       CPU_RST_PULSE;

  modport master (
    output KCLK, RST_SENSE,
    input  RST_DRV, HLT_DRV, CAUSE, CPU_RST_PULSE
  );

  modport slave (
    input  KCLK, RST_SENSE,
    output RST_DRV, HLT_DRV, CAUSE, CPU_RST_PULSE
  );
endinterface

// File: rtl/amiga_reset_ctrl.sv
// Digital A1000 reset timer: power-on and keyboard (KCLK held low) resets onto
// the open-drain _RST/_HLT lines, plus flagging of RESET pulses issued by the 68000.
module amiga_reset_ctrl #(
  parameter int SYNC_STAGES    = 2,
  parameter int POR_CYCLES     = 1431818,
  parameter int KBD_LOW_CYCLES = 71591,
  parameter int RST_MIN_CYCLES = 7159
) (
  input  logic              CLK,
  input  logic              RESET,
  amiga_reset_ctrl_if.slave bus
);

  localparam int POR_W = $clog2(POR_CYCLES) + 1;
  localparam int LOW_W = $clog2(KBD_LOW_CYCLES) + 1;
  localparam int MIN_W = $clog2(RST_MIN_CYCLES) + 1;

  localparam logic [POR_W-1:0] POR_ZERO = {POR_W{1'b0}};
  localparam logic [POR_W-1:0] POR_ONE  = {{(POR_W-1){1'b0}}, 1'b1};
  localparam logic [POR_W-1:0] POR_LAST = POR_W'(POR_CYCLES - 1);
  localparam logic [LOW_W-1:0] LOW_ZERO = {LOW_W{1'b0}};
  localparam logic [LOW_W-1:0] LOW_ONE  = {{(LOW_W-1){1'b0}}, 1'b1};
  localparam logic [LOW_W-1:0] LOW_MAX  = LOW_W'(KBD_LOW_CYCLES);
  localparam logic [MIN_W-1:0] MIN_ZERO = {MIN_W{1'b0}};
  localparam logic [MIN_W-1:0] MIN_ONE  = {{(MIN_W-1){1'b0}}, 1'b1};
  localparam logic [MIN_W-1:0] MIN_LAST = MIN_W'(RST_MIN_CYCLES - 1);

  localparam logic [1:0] CAUSE_POR = 2'b01;
  localparam logic [1:0] CAUSE_KBD = 2'b10;
  localparam logic [SYNC_STAGES-1:0] SYNC_ONES = {SYNC_STAGES{1'b1}};

  typedef enum logic [1:0] {
    POR      = 2'd0,
    RUN      = 2'd1,
    KBD_HOLD = 2'd2,
    KBD_MIN  = 2'd3
  } state_t;

  state_t                 state_r, state_s;
  logic [SYNC_STAGES-1:0] kclk_sync_r, sense_sync_r;
  logic                   sense_prev_r;
  logic                   kclk_s, sense_s;
  logic [POR_W-1:0]       por_cnt_r, por_cnt_s;
  logic [LOW_W-1:0]       low_cnt_r, low_cnt_s;
  logic [MIN_W-1:0]       min_cnt_r, min_cnt_s;
  logic [1:0]             cause_r, cause_s;
  logic                   drv_s, pulse_s;
  logic                   rst_drv_r, hlt_drv_r, pulse_r;

  assign kclk_s  = kclk_sync_r[SYNC_STAGES-1];
  assign sense_s = sense_sync_r[SYNC_STAGES-1];

  // State, counters, synchronisers and registered bus drives.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_r      <= POR;
      kclk_sync_r  <= SYNC_ONES;
      sense_sync_r <= SYNC_ONES;
      sense_prev_r <= 1'b1;
      por_cnt_r    <= POR_ZERO;
      low_cnt_r    <= LOW_ZERO;
      min_cnt_r    <= MIN_ZERO;
      cause_r      <= CAUSE_POR;
      rst_drv_r    <= 1'b1;
      hlt_drv_r    <= 1'b1;
      pulse_r      <= 1'b0;
    end else begin
      state_r      <= state_s;
      kclk_sync_r  <= {kclk_sync_r[SYNC_STAGES-2:0], bus.KCLK};
      sense_sync_r <= {sense_sync_r[SYNC_STAGES-2:0], bus.RST_SENSE};
      sense_prev_r <= sense_s;
      por_cnt_r    <= por_cnt_s;
      low_cnt_r    <= low_cnt_s;
      min_cnt_r    <= min_cnt_s;
      cause_r      <= cause_s;
      rst_drv_r    <= drv_s;
      hlt_drv_r    <= drv_s;
      pulse_r      <= pulse_s;
    end
  end

  // Next state; drives follow the next state so they change on the transition edge.
  always_comb begin
    state_s   = state_r;
    por_cnt_s = por_cnt_r;
    low_cnt_s = LOW_ZERO;
    min_cnt_s = min_cnt_r;
    cause_s   = cause_r;
    pulse_s   = 1'b0;
    case (state_r)
      POR: begin
        if (por_cnt_r == POR_LAST) begin
          state_s   = RUN;
          por_cnt_s = POR_ZERO;
        end else begin
          por_cnt_s = por_cnt_r + POR_ONE;
        end
      end
      RUN: begin
        // Threshold wins over a simultaneous sense edge; the count never passes LOW_MAX.
        if (low_cnt_r == LOW_MAX) begin
          state_s   = KBD_HOLD;
          cause_s   = CAUSE_KBD;
          min_cnt_s = MIN_ZERO;
        end else begin
          if (kclk_s) begin
            low_cnt_s = LOW_ZERO;
          end else begin
            low_cnt_s = low_cnt_r + LOW_ONE;
          end
          if (sense_prev_r && !sense_s && !rst_drv_r) begin
            pulse_s = 1'b1;
          end else begin
            pulse_s = 1'b0;
          end
        end
      end
      KBD_HOLD: begin
        min_cnt_s = MIN_ZERO;
        if (kclk_s) begin
          state_s = KBD_MIN;
        end else begin
          state_s = KBD_HOLD;
        end
      end
      KBD_MIN: begin
        if (!kclk_s) begin
          state_s   = KBD_HOLD;
          min_cnt_s = MIN_ZERO;
        end else if (min_cnt_r == MIN_LAST) begin
          state_s   = RUN;
          min_cnt_s = MIN_ZERO;
        end else begin
          min_cnt_s = min_cnt_r + MIN_ONE;
        end
      end
      default: begin
        state_s   = POR;
        por_cnt_s = POR_ZERO;
        min_cnt_s = MIN_ZERO;
      end
    endcase
    drv_s = (state_s != RUN);
  end

  assign bus.RST_DRV       = rst_drv_r;
  assign bus.HLT_DRV       = hlt_drv_r;
  assign bus.CAUSE         = cause_r;
  assign bus.CPU_RST_PULSE = pulse_r;

endmodule
